// File: rtl/clint_pkg.sv
// Shared constants for the CLINT timer slice: register offsets, reset values, prescaler sizing.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // A divide-by-1 prescaler still needs a 1-bit counter to stay well formed.
    function automatic int presc_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/clint_prescaler.sv
// Free-running divider: o_tick is high on the last count of every TICK_DIV-cycle period.
module clint_prescaler
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);

    localparam int            W    = presc_w(TICK_DIV);
    localparam logic [W-1:0]  LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign o_tick = (cnt_q == LAST);
    assign cnt_d  = o_tick ? '0 : cnt_q + W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/clint_timer.sv
// Machine timer (CLINT subset): mtime/mtimecmp on a single-cycle slave port, registered MTIP.
// Define ARVI_CLINT_MSIP_EN to add the msip register at offset 0x0000 and the o_Int_sip output.
module clint_timer
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [15:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic        o_Int_tip
`ifdef ARVI_CLINT_MSIP_EN
    ,
    output logic        o_Int_sip
`endif
);

    logic        tick;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        ack_q;
    logic [31:0] rdata_q, rdata_d, rd_mux;
    logic        tip_q;
    logic        wr;
    logic [13:0] wa;
    logic        unused_addr_lsb;

    clint_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (tick)
    );

    assign wr              = i_req & i_we;
    assign wa              = i_addr[15:2];
    assign unused_addr_lsb = ^i_addr[1:0];

`ifdef ARVI_CLINT_MSIP_EN
    logic msip_q, msip_d, sip_q;
    assign msip_d    = (wr && wa == CLINT_MSIP[15:2]) ? i_wdata[0] : msip_q;
    assign o_Int_sip = sip_q;
`endif

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        // A bus write to either mtime half suppresses the tick entirely, carry included.
        if (wr && wa == CLINT_MTIME_LO[15:2])      mtime_d[31:0]  = i_wdata;
        else if (wr && wa == CLINT_MTIME_HI[15:2]) mtime_d[63:32] = i_wdata;
        else if (tick)                             mtime_d        = mtime_q + 64'd1;
        if (wr && wa == CLINT_MTIMECMP_LO[15:2])   mtimecmp_d[31:0]  = i_wdata;
        if (wr && wa == CLINT_MTIMECMP_HI[15:2])   mtimecmp_d[63:32] = i_wdata;
    end

    always_comb begin
        rd_mux = '0;
        if (wa == CLINT_MTIMECMP_LO[15:2])      rd_mux = mtimecmp_q[31:0];
        else if (wa == CLINT_MTIMECMP_HI[15:2]) rd_mux = mtimecmp_q[63:32];
        else if (wa == CLINT_MTIME_LO[15:2])    rd_mux = mtime_q[31:0];
        else if (wa == CLINT_MTIME_HI[15:2])    rd_mux = mtime_q[63:32];
`ifdef ARVI_CLINT_MSIP_EN
        else if (wa == CLINT_MSIP[15:2])        rd_mux = {31'b0, msip_q};
`endif
        rdata_d = (i_req && !i_we) ? rd_mux : '0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            tip_q      <= 1'b0;
`ifdef ARVI_CLINT_MSIP_EN
            msip_q     <= 1'b0;
            sip_q      <= 1'b0;
`endif
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ack_q      <= i_req;
            rdata_q    <= rdata_d;
            tip_q      <= (mtime_q >= mtimecmp_q);
`ifdef ARVI_CLINT_MSIP_EN
            msip_q     <= msip_d;
            sip_q      <= msip_q;
`endif
        end
    end

    assign o_ack     = ack_q;
    assign o_rdata   = rdata_q;
    assign o_Int_tip = tip_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: TICK_DIV=4 prescaler instance plus a TICK_DIV=1 instance checked
// against a per-cycle behavioural model, a vector table and directed corner sequences.
module tb_clint_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req1, we1, ack1, tip1;
    logic [15:0] addr1;
    logic [31:0] wd1, rd1;
    logic        req4, we4, ack4, tip4;
    logic [15:0] addr4;
    logic [31:0] wd4, rd4;
`ifdef ARVI_CLINT_MSIP_EN
    logic        sip1, sip4;
`endif

    clint_timer #(.TICK_DIV(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_req(req1), .i_we(we1), .i_addr(addr1), .i_wdata(wd1),
        .o_ack(ack1), .o_rdata(rd1), .o_Int_tip(tip1)
`ifdef ARVI_CLINT_MSIP_EN
        , .o_Int_sip(sip1)
`endif
    );

    clint_timer #(.TICK_DIV(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_req(req4), .i_we(we4), .i_addr(addr4), .i_wdata(wd4),
        .o_ack(ack4), .o_rdata(rd4), .o_Int_tip(tip4)
`ifdef ARVI_CLINT_MSIP_EN
        , .o_Int_sip(sip4)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model of the TICK_DIV=1 instance: architectural registers only.
    logic [63:0] m_time, m_cmp;
    logic        m_msip;
    int          e1, e4;
    logic        a_ack;
    logic [31:0] a_rd;

    function automatic logic [31:0] m_read(input logic [15:0] a);
        case (a & 16'hFFFC)
            16'h4000: return m_cmp[31:0];
            16'h4004: return m_cmp[63:32];
            16'hBFF8: return m_time[31:0];
            16'hBFFC: return m_time[63:32];
`ifdef ARVI_CLINT_MSIP_EN
            16'h0000: return {31'b0, m_msip};
`endif
            default:  return 32'h0;
        endcase
    endfunction

    task automatic bus1(input logic req, input logic we, input logic [15:0] addr, input logic [31:0] wd);
        logic [15:0] a;
        logic [31:0] e_rd;
        logic        e_tip, e_sip, mt_wr;
        req1 = req; we1 = we; addr1 = addr; wd1 = wd;
        a     = addr & 16'hFFFC;
        e_rd  = (req && !we) ? m_read(addr) : 32'h0;
        e_tip = (m_time >= m_cmp);
        e_sip = m_msip;
        mt_wr = req && we && (a == 16'hBFF8 || a == 16'hBFFC);
        if (req && we) begin
            case (a)
                16'h4000: m_cmp[31:0]   = wd;
                16'h4004: m_cmp[63:32]  = wd;
                16'hBFF8: m_time[31:0]  = wd;
                16'hBFFC: m_time[63:32] = wd;
`ifdef ARVI_CLINT_MSIP_EN
                16'h0000: m_msip = wd[0];
`endif
                default: ;
            endcase
        end
        if (!mt_wr) m_time = m_time + 64'd1;
        @(posedge clk); #1;
        req1 = 1'b0; we1 = 1'b0;
        e1++;
        chk("ack", ack1, req);
        chk("rdata", rd1, e_rd);
        chk("tip", tip1, e_tip);
`ifdef ARVI_CLINT_MSIP_EN
        chk("sip", sip1, e_sip);
`endif
        a_ack = ack1;
        a_rd  = rd1;
    endtask

    task automatic rd4_chk(input logic [15:0] addr);
        logic [63:0] t;
        t = 64'(e4 / 4);
        req4 = 1'b1; we4 = 1'b0; addr4 = addr;
        @(posedge clk); #1;
        req4 = 1'b0;
        e4++;
        chk("ack4", ack4, 1);
        chk("rdata4", rd4, (addr == 16'hBFF8) ? t[31:0] : t[63:32]);
        chk("tip4", tip4, 0);
    endtask

    // Reset is asserted together with a live read so the dropped ack is observed.
    task automatic do_reset();
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'hBFF8;
        req4 = 1'b1; we4 = 1'b0; addr4 = 16'hBFF8;
        rst = 1'b0;
        @(posedge clk); #1;
        req1 = 1'b0; req4 = 1'b0;
        chk("rst_ack1", ack1, 0);
        chk("rst_rdata1", rd1, 0);
        chk("rst_tip1", tip1, 0);
        chk("rst_ack4", ack4, 0);
`ifdef ARVI_CLINT_MSIP_EN
        chk("rst_sip1", sip1, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        m_time = 64'h0; m_cmp = '1; m_msip = 1'b0;
        e1 = 0; e4 = 0;
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        ack;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[8];
    logic [15:0] offs[6];

    initial begin
        rst = 1'b0;
        req1 = 0; we1 = 0; addr1 = 0; wd1 = 0;
        req4 = 0; we4 = 0; addr4 = 0; wd4 = 0;

        tbl[0] = '{1'b1, 1'b0, 16'h4000, 32'h0,    1'b1, 32'hFFFF_FFFF};
        tbl[1] = '{1'b1, 1'b1, 16'h8000, 32'h1234, 1'b1, 32'h0};
        tbl[2] = '{1'b1, 1'b0, 16'h8000, 32'h0,    1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 16'h4004, 32'h0,    1'b1, 32'hFFFF_FFFF};
        tbl[4] = '{1'b0, 1'b0, 16'h4000, 32'h0,    1'b0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 16'h0000, 32'h0,    1'b1, 32'h0};
        tbl[6] = '{1'b1, 1'b1, 16'h4000, 32'h55,   1'b1, 32'h0};
        tbl[7] = '{1'b1, 1'b0, 16'h4003, 32'h0,    1'b1, 32'h55};
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h8000};

        @(posedge clk); #1;
        do_reset();

        // TICK_DIV=4: first increment on the 4th edge, 10 after 40 edges.
        for (int k = 0; k < 5; k++) rd4_chk(16'hBFF8);
        while (e4 < 40) begin
            @(posedge clk); #1;
            e4++;
        end
        rd4_chk(16'hBFF8);
        chk("mtime_after_40", rd4, 32'd10);
        rd4_chk(16'hBFFC);
        chk("mtime_hi_after_40", rd4, 32'd0);

        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus1(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            chk($sformatf("tbl%0d_ack", i), a_ack, tbl[i].ack);
            chk($sformatf("tbl%0d_rdata", i), a_rd, tbl[i].rdata);
        end

        // Interrupt rises one edge after mtime reaches 20, falls one edge after hi=1.
        do_reset();
        bus1(1, 1, 16'h4000, 32'd20);
        bus1(1, 1, 16'h4004, 32'd0);
        while (e1 < 30) begin
            bus1(0, 0, 16'h0, 32'h0);
            chk("tip_rise", tip1, (e1 >= 21));
        end
        bus1(1, 1, 16'h4004, 32'd1);
        chk("tip_hold_at_write", tip1, 1);
        bus1(0, 0, 16'h0, 32'h0);
        chk("tip_fall", tip1, 0);

        // 64-bit wrap with mtimecmp at its reset value.
        do_reset();
        bus1(1, 1, 16'hBFF8, 32'hFFFF_FFFF);
        bus1(1, 1, 16'hBFFC, 32'hFFFF_FFFF);
        bus1(0, 0, 16'h0, 32'h0);
        bus1(1, 0, 16'hBFF8, 32'h0);
        chk("wrap_lo", a_rd, 32'h0);
        chk("wrap_tip", tip1, 0);
        bus1(1, 0, 16'hBFFC, 32'h0);
        chk("wrap_hi", a_rd, 32'h0);

        // Write beats tick; no carry into hi on the write edge.
        bus1(1, 1, 16'hBFF8, 32'h100);
        bus1(1, 0, 16'hBFF8, 32'h0);
        chk("write_wins_lo", a_rd, 32'h100);
        bus1(1, 0, 16'hBFFC, 32'h0);
        chk("write_wins_hi", a_rd, 32'h0);
        bus1(1, 1, 16'hBFF8, 32'hFFFF_FFFF);
        bus1(1, 0, 16'hBFFC, 32'h0);
        chk("no_carry_on_write", a_rd, 32'h0);
        bus1(1, 0, 16'hBFFC, 32'h0);
        chk("carry_after_tick", a_rd, 32'h1);

`ifdef ARVI_CLINT_MSIP_EN
        bus1(1, 1, 16'h0000, 32'h1);
        chk("sip_lag", sip1, 0);
        bus1(0, 0, 16'h0, 32'h0);
        chk("sip_set", sip1, 1);
        bus1(1, 0, 16'h0000, 32'h0);
        chk("msip_read", a_rd, 32'h1);
`else
        bus1(1, 1, 16'h0000, 32'h1);
        bus1(1, 0, 16'h0000, 32'h0);
        chk("msip_unmapped", a_rd, 32'h0);
`endif

        do_reset();
        for (int n = 0; n < 300; n++) begin
            logic [15:0] ad;
            logic [31:0] wd;
            ad = offs[$urandom_range(0, 5)] | 16'($urandom_range(0, 3));
            wd = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 400) : $urandom;
            if (ad[15:2] == 14'h2FFF || ad[15:2] == 14'h1001) wd = ($urandom_range(0, 3) == 0) ? wd : 32'h0;
            bus1($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, ad, wd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
